// File: rtl/rominit_xmit.sv
// rominit_xmit
// ------------
// Transmitter side of the ROMINIT write interface. Takes a byte stream from
// the host loader over a valid/ready handshake. It writes the stream into
// either the boot ROM or the VDC character ROM through a one-cycle strobe
// interface.
//   - Short images are padded with 8'hFF up to the image size.
//   - Overlong images have their surplus bytes discarded, and ERR is raised.
//   - The console is held in reset (SYS_RESB low) while an image is loading.
//
// Ports
//   CLK               system clock
//   RES               asynchronous, active-high reset
//   IN_START          one-cycle pulse that begins an image (seen in IDLE/DONE)
//   IN_SEL            image select sampled with IN_START: 0 = boot, 1 = chr
//   IN_VALID/IN_DATA  loader byte and its qualifier
//   IN_LAST           final byte of the stream (meaningful with IN_VALID)
//   IN_READY          a byte is accepted this cycle when IN_VALID is high
//   ROMINIT_SEL_BOOT  boot image selected
//   ROMINIT_SEL_CHR   chr image selected
//   ROMINIT_ADDR      write address (low 12 bits of the address counter)
//   ROMINIT_DATA      write data
//   ROMINIT_VALID     one-cycle write strobe
//   SYS_RESB          console reset, active low
//   BUSY              image transfer in progress
//   ERR               sticky overflow flag, cleared by IN_START
module rominit_xmit #(
  parameter int BOOT_SIZE = 4096,
  parameter int CHR_SIZE  = 1024,
  parameter int GAP       = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        IN_START,
  input  logic        IN_SEL,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_LAST,
  output logic        IN_READY,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic [11:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic        SYS_RESB,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [12:0] BOOT_SIZE_C = 13'(BOOT_SIZE);
  localparam logic [12:0] CHR_SIZE_C  = 13'(CHR_SIZE);
  localparam logic [3:0]  GAP_C       = 4'(GAP);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FILL   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        sel_r, sel_nxt_s;
  logic        sel_boot_r, sel_boot_nxt_s;
  logic        sel_chr_r, sel_chr_nxt_s;
  logic [12:0] cnt_r, cnt_nxt_s;
  logic [3:0]  gap_r, gap_nxt_s;
  logic [7:0]  data_r, data_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        ready_r, ready_nxt_s;
  logic        resb_r, resb_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        err_r, err_nxt_s;

  logic [12:0] size_s;
  logic [12:0] cnt_inc_s;
  logic        accept_s;

  assign size_s    = sel_r ? CHR_SIZE_C : BOOT_SIZE_C;
  assign cnt_inc_s = cnt_r + 13'd1;
  // A byte is taken on any edge where the registered ready meets valid input.
  assign accept_s  = ready_r & IN_VALID;

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_nxt_s    = state_r;
    sel_nxt_s      = sel_r;
    sel_boot_nxt_s = sel_boot_r;
    sel_chr_nxt_s  = sel_chr_r;
    cnt_nxt_s      = cnt_r;
    gap_nxt_s      = gap_r;
    data_nxt_s     = data_r;
    valid_nxt_s    = 1'b0;
    ready_nxt_s    = 1'b0;
    resb_nxt_s     = resb_r;
    busy_nxt_s     = busy_r;
    err_nxt_s      = err_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (IN_START) begin
          sel_nxt_s      = IN_SEL;
          sel_boot_nxt_s = ~IN_SEL;
          sel_chr_nxt_s  = IN_SEL;
          cnt_nxt_s      = 13'd0;
          err_nxt_s      = 1'b0;
          resb_nxt_s     = 1'b0;
          busy_nxt_s     = 1'b1;
          ready_nxt_s    = 1'b1;
          state_nxt_s    = ST_ACCEPT;
        end else begin
          state_nxt_s    = state_r;
        end
      end

      ST_ACCEPT: begin
        if (accept_s) begin
          data_nxt_s  = IN_DATA;
          valid_nxt_s = 1'b1;
          gap_nxt_s   = 4'd0;
          if (IN_LAST && (cnt_inc_s < size_s)) begin
            state_nxt_s = ST_FILL;
          end else if (!IN_LAST && (cnt_inc_s == size_s)) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            // Mid-image byte or exact fit on the last slot.
            state_nxt_s = ST_WAIT;
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end

      // The strobe cycle is gap count 0, so WAIT lasts GAP+1 cycles.
      // ACCEPT then reopens GAP+2 cycles after the previous accept.
      ST_WAIT: begin
        if (gap_r == GAP_C) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == size_s) begin
            sel_boot_nxt_s = 1'b0;
            sel_chr_nxt_s  = 1'b0;
            state_nxt_s    = ST_FINISH;
          end else begin
            ready_nxt_s    = 1'b1;
            state_nxt_s    = ST_ACCEPT;
          end
        end else begin
          gap_nxt_s = gap_r + 4'd1;
        end
      end

      // Pad remaining addresses with 8'hFF, one strobe every GAP+1 cycles.
      ST_FILL: begin
        if (gap_r == GAP_C) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == size_s) begin
            sel_boot_nxt_s = 1'b0;
            sel_chr_nxt_s  = 1'b0;
            state_nxt_s    = ST_FINISH;
          end else begin
            data_nxt_s     = 8'hFF;
            valid_nxt_s    = 1'b1;
            gap_nxt_s      = 4'd0;
          end
        end else begin
          gap_nxt_s = gap_r + 4'd1;
        end
      end

      // Image full: swallow bytes until IN_LAST, flagging the overflow.
      // Ready drops for one cycle after every accept.
      ST_DRAIN: begin
        if (accept_s) begin
          err_nxt_s = 1'b1;
          if (IN_LAST) begin
            sel_boot_nxt_s = 1'b0;
            sel_chr_nxt_s  = 1'b0;
            state_nxt_s    = ST_FINISH;
          end else begin
            state_nxt_s    = ST_DRAIN;
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end

      // Selects are already low here; release the console one cycle later.
      ST_FINISH: begin
        busy_nxt_s  = 1'b0;
        resb_nxt_s  = 1'b1;
        state_nxt_s = ST_DONE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sel_r      <= 1'b0;
      sel_boot_r <= 1'b0;
      sel_chr_r  <= 1'b0;
      cnt_r      <= 13'd0;
      gap_r      <= 4'd0;
      data_r     <= 8'd0;
      valid_r    <= 1'b0;
      ready_r    <= 1'b0;
      resb_r     <= 1'b1;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      sel_r      <= sel_nxt_s;
      sel_boot_r <= sel_boot_nxt_s;
      sel_chr_r  <= sel_chr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      gap_r      <= gap_nxt_s;
      data_r     <= data_nxt_s;
      valid_r    <= valid_nxt_s;
      ready_r    <= ready_nxt_s;
      resb_r     <= resb_nxt_s;
      busy_r     <= busy_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign IN_READY         = ready_r;
  assign ROMINIT_SEL_BOOT = sel_boot_r;
  assign ROMINIT_SEL_CHR  = sel_chr_r;
  assign ROMINIT_ADDR     = cnt_r[11:0];
  assign ROMINIT_DATA     = data_r;
  assign ROMINIT_VALID    = valid_r;
  assign SYS_RESB         = resb_r;
  assign BUSY             = busy_r;
  assign ERR              = err_r;

endmodule

// File: tb/tb_rominit_xmit.sv
// tb_rominit_xmit
// ---------------
// Directed bench for rominit_xmit using the default parameters:
// boot = 4096, chr = 1024, gap = 1.
// A negedge monitor captures every ROM write into a shadow image and tallies
// protocol invariants. The main sequence compares these against images built
// from the known stimulus.
module tb_rominit_xmit;

  logic        CLK;
  logic        RES;
  logic        IN_START;
  logic        IN_SEL;
  logic        IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_LAST;
  logic        IN_READY;
  logic        ROMINIT_SEL_BOOT;
  logic        ROMINIT_SEL_CHR;
  logic [11:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        SYS_RESB;
  logic        BUSY;
  logic        ERR;

  rominit_xmit #(.BOOT_SIZE(4096), .CHR_SIZE(1024), .GAP(1)) dut (
    .CLK(CLK), .RES(RES), .IN_START(IN_START), .IN_SEL(IN_SEL),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT),
    .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR), .ROMINIT_ADDR(ROMINIT_ADDR),
    .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
    .SYS_RESB(SYS_RESB), .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int test_id = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0] mem [0:4095];
  logic       mem_wr [0:4095];
  int mon_id = 0;
  int cyc = 0;
  int strobe_cnt = 0, dup_cnt = 0, period_bad = 0, inv_bad = 0;
  int acc_cnt = 0, boot_seen = 0, prev_cyc = 0, first_addr = -1;
  int sel_fall_cyc = 0, resb_rise_cyc = 0;
  logic have_prev = 1'b0, acc_pend = 1'b0, prev_sel_any = 1'b0, prev_resb = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Byte the loader sends at position idx, or the pad value past the image end.
  function automatic logic [7:0] exp_byte(input int mode, input int idx, input int n_img);
    logic [31:0] v;
    if (idx >= n_img) return 8'hFF;
    if (mode == 0)      v = idx;
    else if (mode == 1) v = idx * 7 + 3;
    else                v = idx ^ 32'h5A;
    return v[7:0];
  endfunction

  // Negedge monitor: shadow ROM, strobe spacing and protocol invariants.
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (test_id != mon_id) begin
      mon_id <= test_id;
      for (int a = 0; a < 4096; a++) begin
        mem[a]    <= 8'h00;
        mem_wr[a] <= 1'b0;
      end
      strobe_cnt <= 0; dup_cnt <= 0; period_bad <= 0; inv_bad <= 0;
      acc_cnt <= 0; boot_seen <= 0; first_addr <= -1; have_prev <= 1'b0;
      sel_fall_cyc <= 0; resb_rise_cyc <= 0; acc_pend <= 1'b0;
    end else begin
      if (ROMINIT_VALID) begin
        strobe_cnt <= strobe_cnt + 1;
        if (strobe_cnt == 0) first_addr <= int'(ROMINIT_ADDR);
        if (mem_wr[ROMINIT_ADDR]) dup_cnt <= dup_cnt + 1;
        mem[ROMINIT_ADDR]    <= ROMINIT_DATA;
        mem_wr[ROMINIT_ADDR] <= 1'b1;
        if (have_prev && (test_id == 1) && (cyc - prev_cyc != 3)) period_bad <= period_bad + 1;
        prev_cyc  <= cyc;
        have_prev <= 1'b1;
      end
      if ((ROMINIT_VALID && !(ROMINIT_SEL_BOOT || ROMINIT_SEL_CHR)) ||
          (ROMINIT_SEL_BOOT && ROMINIT_SEL_CHR) ||
          (acc_pend && IN_READY) ||
          ((ROMINIT_SEL_BOOT || ROMINIT_SEL_CHR || BUSY) && SYS_RESB))
        inv_bad <= inv_bad + 1;
      if (ROMINIT_SEL_BOOT) boot_seen <= boot_seen + 1;
      if (IN_READY && IN_VALID && !RES) acc_cnt <= acc_cnt + 1;
      acc_pend <= IN_READY && IN_VALID && !RES;
      if (prev_sel_any && !(ROMINIT_SEL_BOOT || ROMINIT_SEL_CHR)) sel_fall_cyc <= cyc;
      if (!prev_resb && SYS_RESB && !RES) resb_rise_cyc <= cyc;
    end
    prev_sel_any <= ROMINIT_SEL_BOOT || ROMINIT_SEL_CHR;
    prev_resb    <= SYS_RESB;
  end

  task automatic pulse_start(input logic sel);
    IN_START = 1'b1;
    IN_SEL   = sel;
    @(posedge CLK); #1;
    IN_START = 1'b0;
  endtask

  // Send bytes [first, first+count) of a stream of 'total' bytes.
  task automatic send_bytes(input int first, input int count, input int total,
                            input int mode, input bit rnd);
    for (int i = first; i < first + count; i++) begin
      if (rnd) begin
        int k;
        k = int'($urandom_range(3, 0));
        repeat (k) begin
          IN_VALID = 1'b0;
          IN_DATA  = 8'($urandom);
          IN_LAST  = 1'($urandom);
          @(posedge CLK); #1;
        end
      end
      IN_VALID = 1'b1;
      IN_DATA  = exp_byte(mode, i, 32'h7FFF_FFFF);
      IN_LAST  = (i == total - 1);
      begin
        int waited;
        waited = 0;
        do begin
          @(negedge CLK);
          waited++;
        end while (!IN_READY && waited < 300);
        if (!IN_READY) begin
          check_eq("send_ready_timeout", IN_READY, 1'b1);
          IN_VALID = 1'b0;
          IN_LAST  = 1'b0;
          return;
        end
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (BUSY && n < 20000) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq({tag, "_busy_clear"}, BUSY, 1'b0);
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  task automatic check_image(input string tag, input int size, input int mode, input int n_img);
    int bad, unw;
    bad = 0;
    unw = 0;
    for (int a = 0; a < size; a++) begin
      if (!mem_wr[a]) unw++;
      else if (mem[a] !== exp_byte(mode, a, n_img)) bad++;
    end
    check_eq({tag, "_data_bad"}, bad, 0);
    check_eq({tag, "_unwritten"}, unw, 0);
    check_eq({tag, "_strobes"}, strobe_cnt, size);
    check_eq({tag, "_dup"}, dup_cnt, 0);
    check_eq({tag, "_invariants"}, inv_bad, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, IN_READY, 1'b0);
    check_eq({tag, "_sel_boot"}, ROMINIT_SEL_BOOT, 1'b0);
    check_eq({tag, "_sel_chr"}, ROMINIT_SEL_CHR, 1'b0);
    check_eq({tag, "_addr"}, ROMINIT_ADDR, 12'd0);
    check_eq({tag, "_data"}, ROMINIT_DATA, 8'd0);
    check_eq({tag, "_valid"}, ROMINIT_VALID, 1'b0);
    check_eq({tag, "_busy"}, BUSY, 1'b0);
    check_eq({tag, "_err"}, ERR, 1'b0);
    check_eq({tag, "_resb"}, SYS_RESB, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RES = 1'b1; IN_START = 1'b0; IN_SEL = 1'b0;
    IN_VALID = 1'b0; IN_DATA = 8'd0; IN_LAST = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check_reset_vals("reset");
    RES = 1'b0;
    repeat (2) @(posedge CLK); #1;
    check_eq("idle_ready", IN_READY, 1'b0);
    check_eq("idle_resb", SYS_RESB, 1'b1);

    // Boot image, exact size.
    test_id = 1; @(posedge CLK); #1;
    pulse_start(1'b0);
    check_eq("boot_sel_boot", ROMINIT_SEL_BOOT, 1'b1);
    check_eq("boot_sel_chr", ROMINIT_SEL_CHR, 1'b0);
    check_eq("boot_resb_low", SYS_RESB, 1'b0);
    check_eq("boot_busy", BUSY, 1'b1);
    check_eq("boot_ready", IN_READY, 1'b1);
    send_bytes(0, 4096, 4096, 0, 1'b0);
    wait_done("boot");
    check_image("boot", 4096, 0, 4096);
    check_eq("boot_period", period_bad, 0);
    check_eq("boot_first_addr", first_addr, 0);
    check_eq("boot_err", ERR, 1'b0);
    check_eq("boot_resb_after_sel", resb_rise_cyc - sel_fall_cyc, 1);
    check_eq("boot_resb_high", SYS_RESB, 1'b1);
    check_eq("boot_accepts", acc_cnt, 4096);

    // Chr image, short (100 bytes) with 8'hFF fill.
    test_id = 2; @(posedge CLK); #1;
    pulse_start(1'b1);
    check_eq("short_sel_chr", ROMINIT_SEL_CHR, 1'b1);
    check_eq("short_sel_boot", ROMINIT_SEL_BOOT, 1'b0);
    send_bytes(0, 100, 100, 1, 1'b0);
    wait_done("short");
    check_image("short", 1024, 1, 100);
    check_eq("short_boot_seen", boot_seen, 0);
    check_eq("short_err", ERR, 1'b0);

    // Chr image, overlong (1030 bytes).
    test_id = 3; @(posedge CLK); #1;
    pulse_start(1'b1);
    send_bytes(0, 1024, 1030, 1, 1'b0);
    check_eq("ovf_err_at_1024", ERR, 1'b0);
    send_bytes(1024, 1, 1030, 1, 1'b0);
    check_eq("ovf_err_at_1025", ERR, 1'b1);
    check_eq("ovf_busy_at_1025", BUSY, 1'b1);
    send_bytes(1025, 5, 1030, 1, 1'b0);
    wait_done("ovf");
    check_image("ovf", 1024, 1, 1024);
    check_eq("ovf_err_sticky", ERR, 1'b1);
    check_eq("ovf_accepts", acc_cnt, 1030);

    // Backpressure with random valid gaps, plus an IN_START while busy.
    test_id = 4; @(posedge CLK); #1;
    pulse_start(1'b1);
    check_eq("bp_err_cleared", ERR, 1'b0);
    send_bytes(0, 500, 1024, 2, 1'b1);
    pulse_start(1'b0);
    check_eq("ign_sel_chr", ROMINIT_SEL_CHR, 1'b1);
    check_eq("ign_sel_boot", ROMINIT_SEL_BOOT, 1'b0);
    check_eq("ign_addr", ROMINIT_ADDR, 12'd499);
    check_eq("ign_busy", BUSY, 1'b1);
    check_eq("ign_err", ERR, 1'b0);
    send_bytes(500, 524, 1024, 2, 1'b1);
    wait_done("bp");
    check_image("bp", 1024, 2, 1024);
    check_eq("bp_accepts", acc_cnt, 1024);
    check_eq("bp_boot_seen", boot_seen, 0);
    check_eq("bp_err", ERR, 1'b0);

    // Asynchronous reset in the middle of a boot transfer.
    test_id = 5; @(posedge CLK); #1;
    pulse_start(1'b0);
    send_bytes(0, 2001, 4096, 0, 1'b0);
    check_eq("rst_addr_2000", ROMINIT_ADDR, 12'd2000);
    #2 RES = 1'b1;
    #1 check_reset_vals("midrst");
    repeat (3) @(posedge CLK); #1;
    RES = 1'b0;
    @(posedge CLK); #1;

    // Restart after reset begins at address 0.
    test_id = 6; @(posedge CLK); #1;
    pulse_start(1'b1);
    send_bytes(0, 4, 4, 1, 1'b0);
    wait_done("restart");
    check_eq("restart_first_addr", first_addr, 0);
    check_image("restart", 1024, 1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
